candidate_window_queue: RTL

//  Sits directly downstream of the first-stage classifier cascade. Consumes one pass/fail result per

---
 rtl/face_detect_pkg.sv | 16 +
 rtl/candidate_fifo.sv | 58 +++++
 rtl/candidate_window_queue.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/face_detect_pkg.sv
// Shared types for the face-detection candidate path: window coordinates and scan FSM states.
package face_detect_pkg;

  localparam int unsigned COORD_WIDTH = 10;

  typedef struct packed {
    logic [COORD_WIDTH-1:0] x;
    logic [COORD_WIDTH-1:0] y;
  } window_coord_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

endpackage

// File: rtl/candidate_fifo.sv
// First-word-fall-through FIFO of window coordinates; a push while full is accepted only with a pop.
module candidate_fifo
  import face_detect_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  window_coord_t data_i,
  input  logic          pop_i,
  output window_coord_t data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  window_coord_t mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/candidate_window_queue.sv
// Tags first-stage verdicts with raster window origins, queues passing windows and keeps per-frame stats.
module candidate_window_queue
  import face_detect_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH  = 640,
  parameter int unsigned FRAME_HEIGHT = 480,
  parameter int unsigned WINDOW_SIZE  = 24,
  parameter int unsigned COORD_WIDTH  = face_detect_pkg::COORD_WIDTH,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                          clk_fpga,
  input  logic                          reset_fpga,
  input  logic                          i_frame_start,
  input  logic                          i_window_valid,
  input  logic                          i_iscandidate,
  output logic                          o_cand_valid,
  input  logic                          i_cand_ready,
  output logic [COORD_WIDTH-1:0]        o_cand_x,
  output logic [COORD_WIDTH-1:0]        o_cand_y,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic [CNT_WIDTH-1:0]          o_num_candidates,
  output logic [CNT_WIDTH-1:0]          o_dropped_count,
  output logic                          o_overflow,
  output logic                          o_frame_done
);

  localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(FRAME_WIDTH - WINDOW_SIZE);
  localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(FRAME_HEIGHT - WINDOW_SIZE);

  scan_state_e            state_q, state_d;
  logic [COORD_WIDTH-1:0] x_q, x_d;
  logic [COORD_WIDTH-1:0] y_q, y_d;
  logic [CNT_WIDTH-1:0]   num_q, num_d;
  logic [CNT_WIDTH-1:0]   drop_q, drop_d;
  logic                   ovf_q, ovf_d;
  logic                   done_q, done_d;

  logic                   accept;
  logic                   last_win;
  logic                   push_req;
  logic                   push_ok;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [COORD_WIDTH-1:0] cur_x;
  logic [COORD_WIDTH-1:0] cur_y;
  logic [CNT_WIDTH-1:0]   num_base;
  logic [CNT_WIDTH-1:0]   drop_base;
  window_coord_t          push_data;
  window_coord_t          head;

  // A frame start re-origins the scan in the same cycle, so a coincident window is (0,0).
  assign accept   = i_window_valid && ((state_q == SCAN) || i_frame_start);
  assign cur_x    = i_frame_start ? '0 : x_q;
  assign cur_y    = i_frame_start ? '0 : y_q;
  assign last_win = (cur_x == X_LAST) && (cur_y == Y_LAST);
  assign push_req = accept && i_iscandidate;
  assign pop      = o_cand_valid && i_cand_ready;
  assign push_ok  = push_req && (!fifo_full || pop);

  assign push_data.x = cur_x;
  assign push_data.y = cur_y;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    num_base  = i_frame_start ? '0 : num_q;
    drop_base = i_frame_start ? '0 : drop_q;
    num_d     = num_base;
    drop_d    = drop_base;
    ovf_d     = i_frame_start ? 1'b0 : ovf_q;
    done_d    = 1'b0;

    if (i_frame_start) begin
      state_d = SCAN;
      x_d     = '0;
      y_d     = '0;
    end

    if (accept) begin
      if (last_win) begin
        state_d = IDLE;
        x_d     = '0;
        y_d     = '0;
        done_d  = 1'b1;
      end else if (cur_x == X_LAST) begin
        x_d = '0;
        y_d = cur_y + 1'b1;
      end else begin
        x_d = cur_x + 1'b1;
        y_d = cur_y;
      end
    end

    if (push_ok && (num_base != '1)) begin
      num_d = num_base + 1'b1;
    end
    if (push_req && !push_ok) begin
      ovf_d = 1'b1;
      if (drop_base != '1) begin
        drop_d = drop_base + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      num_q   <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      num_q   <= num_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  candidate_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_fpga),
    .rst_i   (reset_fpga),
    .push_i  (push_ok),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (o_fifo_count)
  );

  assign o_cand_valid     = !fifo_empty;
  assign o_cand_x         = head.x;
  assign o_cand_y         = head.y;
  assign o_num_candidates = num_q;
  assign o_dropped_count  = drop_q;
  assign o_overflow       = ovf_q;
  assign o_frame_done     = done_q;

endmodule
